// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan decoder:
// default settle window, FSM encoding, segment table and anode helpers.
package seg_pkg;

  localparam int SETTLE_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } scan_state_t;

  // Raw pin image, all fields active-low as seen on the board.
  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
  } scan_sample_t;

  // Active-high gfedcba patterns for hex digits 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic an_legal(input logic [7:0] an);
    return $countones(~an) == 1;
  endfunction

  function automatic logic [2:0] an_index(input logic [7:0] an);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational decode of an active-high gfedcba pattern into a hex nibble,
// flagging fully-dark patterns as blank and unknown patterns as errors.
module seg7_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       err
);

  always_comb begin
    nibble = 4'h0;
    blank  = (seg == 7'h00);
    err    = (seg != 7'h00);
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        nibble = 4'(i);
        err    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the hex digits shown on a multiplexed 8-digit seven-segment display
// by waiting for each scanned pattern to settle and capturing it once.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        CA,
  input  logic        CB,
  input  logic        CC,
  input  logic        CD,
  input  logic        CE,
  input  logic        CF,
  input  logic        CG,
  input  logic        DP,
  input  logic [7:0]  AN,
  output logic [31:0] digits,
  output logic [7:0]  dp_mask,
  output logic [7:0]  blank_mask,
  output logic [7:0]  err_mask,
  output logic        digit_valid,
  output logic [2:0]  digit_idx,
  output logic        frame_valid
);

  scan_sample_t smp_p0;
  scan_sample_t prev_q;
  scan_state_t  state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [7:0]   seen_q;
  logic         changed, cnt_hit, cap;
  logic [2:0]   cap_idx;
  logic [3:0]   nib;
  logic         nib_blank, nib_err;

  // Stage p0: register the pins; previous sample starts as a blanked display.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      smp_p0 <= '1;
      prev_q <= '1;
      cnt_q  <= 8'd0;
    end else begin
      smp_p0 <= {CG, CF, CE, CD, CC, CB, CA, DP, AN};
      prev_q <= smp_p0;
      cnt_q  <= cnt_d;
    end
  end

  assign changed = (smp_p0 != prev_q);
  assign cnt_hit = ((cnt_q + 8'd1) == 8'(SETTLE_CYCLES));
  assign cap_idx = an_index(smp_p0.an);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (changed)
      state_d = ST_SETTLE;
    else if (state_q == ST_SETTLE && cnt_hit)
      state_d = an_legal(smp_p0.an) ? ST_HOLD : ST_IDLE;
  end

  always_comb begin
    cnt_d = cnt_q;
    cap   = 1'b0;
    if (changed) begin
      cnt_d = 8'd1;
    end else if (state_q == ST_SETTLE) begin
      cnt_d = cnt_q + 8'd1;
      cap   = cnt_hit && an_legal(smp_p0.an);
    end
  end

  seg7_to_hex u_dec (
    .seg    (~smp_p0.seg),
    .nibble (nib),
    .blank  (nib_blank),
    .err    (nib_err)
  );

  // Stage p1: capture into the digit array and track frame completion.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      digits      <= 32'd0;
      dp_mask     <= 8'd0;
      blank_mask  <= 8'd0;
      err_mask    <= 8'd0;
      seen_q      <= 8'd0;
      digit_valid <= 1'b0;
      digit_idx   <= 3'd0;
      frame_valid <= 1'b0;
    end else begin
      digit_valid <= cap;
      frame_valid <= (seen_q == 8'hFF);
      // A capture landing on the frame pulse seeds the next frame's mask.
      seen_q <= ((seen_q == 8'hFF) ? 8'h00 : seen_q) | (cap ? (8'b1 << cap_idx) : 8'h00);
      if (cap) begin
        digits[{cap_idx, 2'b00} +: 4] <= nib;
        dp_mask[cap_idx]              <= ~smp_p0.dp;
        blank_mask[cap_idx]           <= nib_blank;
        err_mask[cap_idx]             <= nib_err;
        digit_idx                     <= cap_idx;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with SETTLE_CYCLES = 4.
module tb_seg_scan_decoder;

  logic        sys_clk, sys_rst;
  logic        CA, CB, CC, CD, CE, CF, CG, DP;
  logic [7:0]  AN;
  logic [31:0] digits;
  logic [7:0]  dp_mask, blank_mask, err_mask;
  logic        digit_valid, frame_valid;
  logic [2:0]  digit_idx;

  int checks = 0;
  int errors = 0;
  int dv_cnt, fv_cnt, first_dv, last_idx;

  logic [6:0] seg_tab [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};

  seg_scan_decoder #(.SETTLE_CYCLES(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG), .DP(DP), .AN(AN),
    .digits(digits), .dp_mask(dp_mask), .blank_mask(blank_mask), .err_mask(err_mask),
    .digit_valid(digit_valid), .digit_idx(digit_idx), .frame_valid(frame_valid)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic drive(input logic [6:0] g, input logic dp_lit, input logic [7:0] an);
    {CG, CF, CE, CD, CC, CB, CA} = ~g;
    DP = ~dp_lit;
    AN = an;
  endtask

  task automatic clr_counts();
    dv_cnt = 0; fv_cnt = 0; first_dv = 0; last_idx = -1;
  endtask

  task automatic step(input int n);
    for (int i = 1; i <= n; i++) begin
      @(posedge sys_clk); #1;
      if (digit_valid === 1'b1) begin
        dv_cnt++;
        last_idx = int'(digit_idx);
        if (first_dv == 0) first_dv = i;
      end
      if (frame_valid === 1'b1) fv_cnt++;
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    drive(7'h00, 1'b0, 8'hFF);
    @(posedge sys_clk); #1;
    checks++; if (digits !== 32'd0) begin errors++; $display("FAIL reset_digits: got %h expected %h", digits, 32'd0); end
    checks++; if ({dp_mask, blank_mask, err_mask} !== 24'd0) begin errors++; $display("FAIL reset_masks: got %h expected %h", {dp_mask, blank_mask, err_mask}, 24'd0); end
    checks++; if ({digit_valid, frame_valid, digit_idx} !== 5'd0) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", {digit_valid, frame_valid, digit_idx}, 5'd0); end
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
  endtask

  task automatic test_single_digit();
    clr_counts();
    drive(7'h4F, 1'b0, 8'hFE);
    step(10);
    checks++; if (dv_cnt != 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", dv_cnt); end
    checks++; if (first_dv != 5) begin errors++; $display("FAIL single_latency: got %0d expected 5", first_dv); end
    checks++; if (last_idx != 0) begin errors++; $display("FAIL single_idx: got %0d expected 0", last_idx); end
    checks++; if (digits[3:0] !== 4'h3) begin errors++; $display("FAIL single_nibble: got %h expected 3", digits[3:0]); end
    checks++; if ({dp_mask[0], blank_mask[0], err_mask[0]} !== 3'b000) begin errors++; $display("FAIL single_masks: got %b expected 000", {dp_mask[0], blank_mask[0], err_mask[0]}); end
  endtask

  task automatic test_scan_frame();
    clr_counts();
    for (int d = 0; d < 8; d++) begin
      drive(seg_tab[d], 1'b0, ~(8'b1 << d));
      step(6);
    end
    step(3);
    checks++; if (dv_cnt != 8) begin errors++; $display("FAIL scan_pulses: got %0d expected 8", dv_cnt); end
    checks++; if (fv_cnt != 1) begin errors++; $display("FAIL scan_frame: got %0d expected 1", fv_cnt); end
    checks++; if (digits !== 32'h76543210) begin errors++; $display("FAIL scan_digits: got %h expected 76543210", digits); end
    checks++; if ({dp_mask, blank_mask, err_mask} !== 24'd0) begin errors++; $display("FAIL scan_masks: got %h expected 0", {dp_mask, blank_mask, err_mask}); end
  endtask

  task automatic test_glitch();
    clr_counts();
    for (int t = 0; t < 10; t++) begin
      drive((t % 2 == 0) ? 7'h06 : 7'h5B, 1'b0, 8'hFD);
      step(2);
    end
    checks++; if (dv_cnt != 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", dv_cnt); end
    clr_counts();
    drive(7'h7F, 1'b0, 8'hFD);
    step(5);
    checks++; if (dv_cnt != 1) begin errors++; $display("FAIL glitch_stable: got %0d expected 1", dv_cnt); end
    checks++; if (digits[7:4] !== 4'h8) begin errors++; $display("FAIL glitch_nibble: got %h expected 8", digits[7:4]); end
  endtask

  task automatic test_illegal_an();
    logic [55:0] snap;
    snap = {digits, dp_mask, blank_mask, err_mask};
    clr_counts();
    drive(7'h3F, 1'b1, 8'hFC);
    step(10);
    checks++; if (dv_cnt != 0) begin errors++; $display("FAIL illegal_two_pulses: got %0d expected 0", dv_cnt); end
    drive(7'h3F, 1'b1, 8'hFF);
    step(10);
    checks++; if (dv_cnt != 0) begin errors++; $display("FAIL illegal_none_pulses: got %0d expected 0", dv_cnt); end
    checks++; if ({digits, dp_mask, blank_mask, err_mask} !== snap) begin errors++; $display("FAIL illegal_state: got %h expected %h", {digits, dp_mask, blank_mask, err_mask}, snap); end
  endtask

  task automatic test_masks();
    drive(7'h00, 1'b0, 8'hFB);
    step(8);
    checks++; if ({blank_mask[2], err_mask[2], digits[11:8]} !== 6'b10_0000) begin errors++; $display("FAIL blank_digit2: got %b expected 100000", {blank_mask[2], err_mask[2], digits[11:8]}); end
    drive(7'h01, 1'b0, 8'hDF);
    step(8);
    checks++; if ({err_mask[5], blank_mask[5], digits[23:20]} !== 6'b10_0000) begin errors++; $display("FAIL err_digit5: got %b expected 100000", {err_mask[5], blank_mask[5], digits[23:20]}); end
    drive(7'h7D, 1'b1, 8'hBF);
    step(8);
    checks++; if ({dp_mask[6], digits[27:24]} !== 5'b1_0110) begin errors++; $display("FAIL dp_digit6: got %b expected 10110", {dp_mask[6], digits[27:24]}); end
  endtask

  task automatic test_reset_mid();
    sys_rst = 1'b1; #2; sys_rst = 1'b0;
    clr_counts();
    for (int d = 0; d < 5; d++) begin
      drive(seg_tab[(d + 3) % 8], 1'b0, ~(8'b1 << d));
      step(6);
    end
    checks++; if (dv_cnt != 5 || fv_cnt != 0) begin errors++; $display("FAIL mid_prefill: got %0d/%0d expected 5/0", dv_cnt, fv_cnt); end
    drive(seg_tab[5], 1'b0, 8'hDF);
    step(2);
    sys_rst = 1'b1;
    #1;
    checks++; if ({digits, dp_mask, blank_mask, err_mask} !== 56'd0) begin errors++; $display("FAIL mid_reset_data: got %h expected 0", {digits, dp_mask, blank_mask, err_mask}); end
    checks++; if ({digit_valid, frame_valid, digit_idx} !== 5'd0) begin errors++; $display("FAIL mid_reset_ctrl: got %b expected 00000", {digit_valid, frame_valid, digit_idx}); end
    @(posedge sys_clk); @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    clr_counts();
    step(6);
    checks++; if (first_dv != 5 || last_idx != 5) begin errors++; $display("FAIL mid_first_capture: got at %0d idx %0d expected at 5 idx 5", first_dv, last_idx); end
    for (int d = 6; d < 8; d++) begin
      drive(seg_tab[d], 1'b0, ~(8'b1 << d));
      step(6);
    end
    checks++; if (fv_cnt != 0) begin errors++; $display("FAIL mid_no_early_frame: got %0d expected 0", fv_cnt); end
    for (int d = 0; d < 5; d++) begin
      drive(seg_tab[d], 1'b0, ~(8'b1 << d));
      step(6);
    end
    step(2);
    checks++; if (fv_cnt != 1 || dv_cnt != 8) begin errors++; $display("FAIL mid_fresh_frame: got %0d frames %0d caps expected 1/8", fv_cnt, dv_cnt); end
    checks++; if (digits !== 32'h76543210) begin errors++; $display("FAIL mid_digits: got %h expected 76543210", digits); end
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_scan_frame();
    test_glitch();
    test_illegal_an();
    test_masks();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
